// File: rtl/i2c_write_ctrl.sv
// I2C write controller: sends START, address byte, two payload bytes (each ACK-checked) and STOP.
// Each step is handed to the bit-stream engine as a command with a ready handshake.
module i2c_write_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic [2:0]  cmd,
  input  logic        ready,
  input  logic        sck_mon,
  input  logic        sda_in
);

  localparam logic [2:0] CMDIDLE  = 3'd0;
  localparam logic [2:0] CMDWAIT  = 3'd1;
  localparam logic [2:0] CMDSTART = 3'd2;
  localparam logic [2:0] CMDSTOP  = 3'd3;
  localparam logic [2:0] CMDBIT0  = 3'd4;
  localparam logic [2:0] CMDBIT1  = 3'd5;
  localparam logic [2:0] CMDRBIT  = 3'd6;

  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b0};

  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, DONE} state_t;
  typedef enum logic {ISSUE, RELEASE} phase_t;

  state_t      state_reg, state_next;
  phase_t      phase_reg, phase_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] shift_reg, shift_next;
  logic        nack_reg, nack_next;
  logic        ack_reg, ack_next;
  logic        cur_bit;
  logic [2:0]  issue_cmd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      phase_reg    <= ISSUE;
      byte_cnt_reg <= 2'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 16'd0;
      nack_reg     <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      byte_cnt_reg <= byte_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      nack_reg     <= nack_next;
      ack_reg      <= ack_next;
    end
  end

  // Address byte is a constant; payload bytes stream out of the top of the shift register.
  assign cur_bit = (byte_cnt_reg == 2'd0) ? ADDR_BYTE[bit_cnt_reg] : shift_reg[15];

  always_comb begin
    issue_cmd = CMDWAIT;
    case (state_reg)
      START:   issue_cmd = CMDSTART;
      BYTE:    issue_cmd = cur_bit ? CMDBIT1 : CMDBIT0;
      ACK:     issue_cmd = CMDRBIT;
      STOP:    issue_cmd = CMDSTOP;
      default: issue_cmd = CMDWAIT;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    byte_cnt_next = byte_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    nack_next     = nack_reg;
    ack_next      = ack_reg;
    cmd           = CMDWAIT;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next    = wdata;
          nack_next     = 1'b0;
          byte_cnt_next = 2'd0;
          bit_cnt_next  = 3'd7;
          phase_next    = ISSUE;
          state_next    = START;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy = 1'b1;
        if (phase_reg == ISSUE) begin
          cmd = issue_cmd;
          if (state_reg == ACK && sck_mon)
            ack_next = sda_in;
          if (ready)
            phase_next = RELEASE;
        end else if (!ready) begin
          phase_next = ISSUE;
          case (state_reg)
            START: state_next = BYTE;
            BYTE: begin
              if (byte_cnt_reg != 2'd0)
                shift_next = {shift_reg[14:0], 1'b0};
              if (bit_cnt_reg == 3'd0) begin
                // Assume NACK until sda is actually sampled with sck high.
                ack_next   = 1'b1;
                state_next = ACK;
              end else begin
                bit_cnt_next = bit_cnt_reg - 3'd1;
              end
            end
            ACK: begin
              bit_cnt_next = 3'd7;
              if (ack_reg) begin
                nack_next  = 1'b1;
                state_next = STOP;
              end else if (byte_cnt_reg == 2'd2) begin
                state_next = STOP;
              end else begin
                byte_cnt_next = byte_cnt_reg + 2'd1;
                state_next    = BYTE;
              end
            end
            STOP:    state_next = DONE;
            default: state_next = IDLE;
          endcase
        end
      end
    endcase
  end

  assign nack = nack_reg;

endmodule
